// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the dual-issue controller: register-address width,
// FSM state encoding and the per-slot decode bundle.
package issue_ctrl_pkg;

  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic {
    ST_PAIR = 1'b0,
    ST_HALF = 1'b1
  } state_e;

  typedef struct packed {
    logic      valid;
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic      use_rs1;
    logic      use_rs2;
    logic      rd_we;
    logic      is_mem;
  } slot_t;

  // Younger slot depends on the older one when it reads or rewrites the
  // older slot's destination; x0 never creates a dependency.
  function automatic logic pair_dep(slot_t s0, slot_t s1);
    logic hit;
    hit = (s1.use_rs1 && (s1.rs1 == s0.rd)) ||
          (s1.use_rs2 && (s1.rs2 == s0.rd)) ||
          (s1.rd_we   && (s1.rd  == s0.rd));
    return s0.rd_we && (s0.rd != '0) && hit;
  endfunction

endpackage

// File: rtl/issue_ctrl_hazard_check.sv
// Per-slot hazard detect against the scoreboard, with same-cycle writeback
// bypass: a register being written back this cycle is treated as free.
module hazard_check
  import issue_ctrl_pkg::*;
(
  input  logic                valid_i,
  input  logic [REG_AW-1:0]   rs1_i,
  input  logic [REG_AW-1:0]   rs2_i,
  input  logic [REG_AW-1:0]   rd_i,
  input  logic                use_rs1_i,
  input  logic                use_rs2_i,
  input  logic                rd_we_i,
  input  logic [NUM_REGS-1:0] busy_i,
  input  logic                wb_we0_i,
  input  logic [REG_AW-1:0]   wb_addr0_i,
  input  logic                wb_we1_i,
  input  logic [REG_AW-1:0]   wb_addr1_i,
  output logic                hazard_o
);

  logic [NUM_REGS-1:0] busy_eff;

  // Mask out registers retiring this cycle, then test the used operands.
  always_comb begin
    busy_eff = busy_i;
    if (wb_we0_i) busy_eff[wb_addr0_i] = 1'b0;
    if (wb_we1_i) busy_eff[wb_addr1_i] = 1'b0;
    hazard_o = valid_i &&
               ((use_rs1_i && busy_eff[rs1_i]) ||
                (use_rs2_i && busy_eff[rs2_i]) ||
                (rd_we_i && (rd_i != '0) && busy_eff[rd_i]));
  end

endmodule

// File: rtl/issue_ctrl.sv
// In-order dual-issue controller with a 32-entry register scoreboard.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_PAIR | both decode slots pending (or decode empty)
//   ST_HALF | slot 0 already issued, slot 1 still waiting to issue
module issue_ctrl
  import issue_ctrl_pkg::*;
(
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                valid0_i,
  input  logic                valid1_i,
  input  logic [REG_AW-1:0]   rs1_0_i,
  input  logic [REG_AW-1:0]   rs2_0_i,
  input  logic [REG_AW-1:0]   rd_0_i,
  input  logic [REG_AW-1:0]   rs1_1_i,
  input  logic [REG_AW-1:0]   rs2_1_i,
  input  logic [REG_AW-1:0]   rd_1_i,
  input  logic                use_rs1_0_i,
  input  logic                use_rs2_0_i,
  input  logic                rd_we_0_i,
  input  logic                use_rs1_1_i,
  input  logic                use_rs2_1_i,
  input  logic                rd_we_1_i,
  input  logic                is_mem0_i,
  input  logic                is_mem1_i,
  input  logic [REG_AW-1:0]   wb_addr0_i,
  input  logic [REG_AW-1:0]   wb_addr1_i,
  input  logic                wb_we0_i,
  input  logic                wb_we1_i,
  input  logic                exec_stall_i,
  input  logic                flush_i,
  output logic                issue0_o,
  output logic                issue1_o,
  output logic                stall_o,
  output logic [NUM_REGS-1:0] busy_o
);

  state_e              state_q, state_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  slot_t               slot0, slot1;
  logic                hazard0, hazard1;
  logic                mem_conflict, dep01, can_go;

  assign slot0 = '{valid: valid0_i, rs1: rs1_0_i, rs2: rs2_0_i, rd: rd_0_i,
                   use_rs1: use_rs1_0_i, use_rs2: use_rs2_0_i,
                   rd_we: rd_we_0_i, is_mem: is_mem0_i};
  assign slot1 = '{valid: valid1_i, rs1: rs1_1_i, rs2: rs2_1_i, rd: rd_1_i,
                   use_rs1: use_rs1_1_i, use_rs2: use_rs2_1_i,
                   rd_we: rd_we_1_i, is_mem: is_mem1_i};

  hazard_check u_hz0 (
    .valid_i(slot0.valid), .rs1_i(slot0.rs1), .rs2_i(slot0.rs2), .rd_i(slot0.rd),
    .use_rs1_i(slot0.use_rs1), .use_rs2_i(slot0.use_rs2), .rd_we_i(slot0.rd_we),
    .busy_i(busy_q), .wb_we0_i(wb_we0_i), .wb_addr0_i(wb_addr0_i),
    .wb_we1_i(wb_we1_i), .wb_addr1_i(wb_addr1_i), .hazard_o(hazard0)
  );

  hazard_check u_hz1 (
    .valid_i(slot1.valid), .rs1_i(slot1.rs1), .rs2_i(slot1.rs2), .rd_i(slot1.rd),
    .use_rs1_i(slot1.use_rs1), .use_rs2_i(slot1.use_rs2), .rd_we_i(slot1.rd_we),
    .busy_i(busy_q), .wb_we0_i(wb_we0_i), .wb_addr0_i(wb_addr0_i),
    .wb_we1_i(wb_we1_i), .wb_addr1_i(wb_addr1_i), .hazard_o(hazard1)
  );

  // Only one memory unit, so two memory ops never go together.
  assign mem_conflict = slot0.is_mem & slot1.is_mem;
  assign dep01        = pair_dep(slot0, slot1);
  assign can_go       = !exec_stall_i && !flush_i && !reset_i;

  // State register.
  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= ST_PAIR;
    else         state_q <= state_d;
  end

  // Next state: split a pair into HALF when only slot 0 goes.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_PAIR;
    end else if (state_q == ST_HALF) begin
      if (issue1_o) state_d = ST_PAIR;
    end else begin
      if (issue0_o && !issue1_o && valid1_i) state_d = ST_HALF;
    end
  end

  // Issue and stall outputs; all forced low during reset and flush.
  always_comb begin
    issue0_o = 1'b0;
    issue1_o = 1'b0;
    stall_o  = 1'b0;
    if (state_q == ST_HALF) begin
      issue1_o = !hazard1 && can_go;
      stall_o  = !issue1_o && !flush_i && !reset_i;
    end else begin
      issue0_o = valid0_i && !hazard0 && can_go;
      issue1_o = issue0_o && valid1_i && !hazard1 && !mem_conflict && !dep01;
      stall_o  = valid0_i && !(issue0_o && (issue1_o || !valid1_i)) &&
                 !flush_i && !reset_i;
    end
  end

  // Scoreboard next value: writebacks clear first so a new issue wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_we0_i) busy_d[wb_addr0_i] = 1'b0;
    if (wb_we1_i) busy_d[wb_addr1_i] = 1'b0;
    if (issue0_o && rd_we_0_i) busy_d[rd_0_i] = 1'b1;
    if (issue1_o && rd_we_1_i) busy_d[rd_1_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clock_i) begin
    if (reset_i) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Testbench for issue_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the issue rules.
module tb_issue_ctrl;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        valid0_i, valid1_i;
  logic [4:0]  rs1_0_i, rs2_0_i, rd_0_i, rs1_1_i, rs2_1_i, rd_1_i;
  logic        use_rs1_0_i, use_rs2_0_i, rd_we_0_i;
  logic        use_rs1_1_i, use_rs2_1_i, rd_we_1_i;
  logic        is_mem0_i, is_mem1_i;
  logic [4:0]  wb_addr0_i, wb_addr1_i;
  logic        wb_we0_i, wb_we1_i;
  logic        exec_stall_i, flush_i;
  logic        issue0_o, issue1_o, stall_o;
  logic [31:0] busy_o;

  int total = 0;
  int bad   = 0;

  // Model: set of registers with an outstanding writer, plus whether the
  // younger slot of the current pair is still owed an issue.
  bit m_busy [32];
  bit m_owed;

  logic o_i0, o_i1, o_st;

  always #5 clock_i = ~clock_i;

  issue_ctrl dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .valid0_i(valid0_i), .valid1_i(valid1_i),
    .rs1_0_i(rs1_0_i), .rs2_0_i(rs2_0_i), .rd_0_i(rd_0_i),
    .rs1_1_i(rs1_1_i), .rs2_1_i(rs2_1_i), .rd_1_i(rd_1_i),
    .use_rs1_0_i(use_rs1_0_i), .use_rs2_0_i(use_rs2_0_i), .rd_we_0_i(rd_we_0_i),
    .use_rs1_1_i(use_rs1_1_i), .use_rs2_1_i(use_rs2_1_i), .rd_we_1_i(rd_we_1_i),
    .is_mem0_i(is_mem0_i), .is_mem1_i(is_mem1_i),
    .wb_addr0_i(wb_addr0_i), .wb_addr1_i(wb_addr1_i),
    .wb_we0_i(wb_we0_i), .wb_we1_i(wb_we1_i),
    .exec_stall_i(exec_stall_i), .flush_i(flush_i),
    .issue0_o(issue0_o), .issue1_o(issue1_o), .stall_o(stall_o),
    .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register r blocks issue this cycle unless x0 or retiring right now.
  function automatic bit pend(int r);
    if (r == 0) return 1'b0;
    if (wb_we0_i && int'(wb_addr0_i) == r) return 1'b0;
    if (wb_we1_i && int'(wb_addr1_i) == r) return 1'b0;
    return m_busy[r];
  endfunction

  task automatic set0(input bit v, input int a, input int b, input int d,
                      input bit ua, input bit ub, input bit we, input bit mem);
    valid0_i = v; rs1_0_i = 5'(a); rs2_0_i = 5'(b); rd_0_i = 5'(d);
    use_rs1_0_i = ua; use_rs2_0_i = ub; rd_we_0_i = we; is_mem0_i = mem;
  endtask

  task automatic set1(input bit v, input int a, input int b, input int d,
                      input bit ua, input bit ub, input bit we, input bit mem);
    valid1_i = v; rs1_1_i = 5'(a); rs2_1_i = 5'(b); rd_1_i = 5'(d);
    use_rs1_1_i = ua; use_rs2_1_i = ub; rd_we_1_i = we; is_mem1_i = mem;
  endtask

  task automatic idle();
    set0(0, 0, 0, 0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0, 0, 0, 0);
    wb_we0_i = 0; wb_we1_i = 0; wb_addr0_i = 0; wb_addr1_i = 0;
    exec_stall_i = 0; flush_i = 0; reset_i = 0;
  endtask

  // One clock: compare outputs against the model, advance the model, tick.
  task automatic step();
    bit h0, h1, dep, e0, e1, es, owed_n;
    logic [31:0] exp_busy;
    #1;
    h0 = valid0_i && ((use_rs1_0_i && pend(rs1_0_i)) || (use_rs2_0_i && pend(rs2_0_i)) ||
                      (rd_we_0_i && pend(rd_0_i)));
    h1 = valid1_i && ((use_rs1_1_i && pend(rs1_1_i)) || (use_rs2_1_i && pend(rs2_1_i)) ||
                      (rd_we_1_i && pend(rd_1_i)));
    dep = rd_we_0_i && rd_0_i != 0 &&
          ((use_rs1_1_i && rs1_1_i == rd_0_i) || (use_rs2_1_i && rs2_1_i == rd_0_i) ||
           (rd_we_1_i && rd_1_i == rd_0_i));
    if (reset_i) begin
      e0 = 0; e1 = 0; es = 0; owed_n = 0;
    end else if (!m_owed) begin
      e0 = valid0_i && !h0 && !exec_stall_i && !flush_i;
      e1 = e0 && valid1_i && !h1 && !(is_mem0_i && is_mem1_i) && !dep;
      es = !flush_i && valid0_i && !(e0 && (e1 || !valid1_i));
      owed_n = e0 && !e1 && valid1_i;
    end else begin
      e0 = 0;
      e1 = !h1 && !exec_stall_i && !flush_i;
      es = !flush_i && !e1;
      owed_n = !(e1 || flush_i);
    end
    for (int r = 0; r < 32; r++) exp_busy[r] = m_busy[r];
    chk("issue0", issue0_o, e0);
    chk("issue1", issue1_o, e1);
    chk("stall", stall_o, es);
    chk("busy", busy_o, exp_busy);
    o_i0 = issue0_o; o_i1 = issue1_o; o_st = stall_o;
    if (reset_i) begin
      for (int r = 0; r < 32; r++) m_busy[r] = 0;
    end else begin
      if (wb_we0_i) m_busy[wb_addr0_i] = 0;
      if (wb_we1_i) m_busy[wb_addr1_i] = 0;
      if (e0 && rd_we_0_i && rd_0_i != 0) m_busy[rd_0_i] = 1;
      if (e1 && rd_we_1_i && rd_1_i != 0) m_busy[rd_1_i] = 1;
    end
    m_owed = owed_n;
    @(posedge clock_i);
    #1;
  endtask

  initial begin
    bit hold;
    idle();
    reset_i = 1;
    for (int r = 0; r < 32; r++) m_busy[r] = 0;
    m_owed = 0;
    @(posedge clock_i);
    #1;

    // Reset held: outputs quiet even with a valid pair presented.
    set0(1, 0, 0, 3, 0, 0, 1, 0);
    step();
    chk("rst_i0", o_i0, 0);
    chk("rst_st", o_st, 0);
    idle();

    // Independent pair goes together.
    set0(1, 0, 0, 1, 0, 0, 1, 0);
    set1(1, 0, 0, 2, 0, 0, 1, 0);
    step();
    chk("pair_i0", o_i0, 1);
    chk("pair_i1", o_i1, 1);
    chk("pair_st", o_st, 0);
    idle();
    chk("pair_busy", busy_o, 32'h6);
    step();

    // RAW inside the pair: split, then wait for x5 writeback (bypassed).
    set0(1, 0, 0, 5, 0, 0, 1, 0);
    set1(1, 5, 0, 0, 1, 0, 0, 0);
    step();
    chk("raw_i0", o_i0, 1);
    chk("raw_i1", o_i1, 0);
    chk("raw_st", o_st, 1);
    step();
    chk("raw_wait_i1", o_i1, 0);
    wb_we0_i = 1; wb_addr0_i = 5;
    step();
    chk("raw_wb_i1", o_i1, 1);
    chk("raw_wb_st", o_st, 0);
    idle();

    // Two loads share one memory unit.
    set0(1, 0, 0, 8, 0, 0, 1, 1);
    set1(1, 0, 0, 9, 0, 0, 1, 1);
    step();
    chk("mem_st0", o_st, 1);
    step();
    chk("mem_i1", o_i1, 1);
    chk("mem_st1", o_st, 0);
    idle();

    // Source busy but retiring on wb port 1 the same cycle.
    set0(1, 0, 0, 7, 0, 0, 1, 0);
    step();
    chk("byp_busy7", busy_o & 32'h80, 32'h80);
    set0(1, 7, 0, 0, 1, 0, 0, 0);
    wb_we1_i = 1; wb_addr1_i = 7;
    step();
    chk("byp_i0", o_i0, 1);
    idle();

    // Execute stall while in HALF, then flush back to PAIR.
    set0(1, 0, 0, 10, 0, 0, 1, 0);
    set1(1, 10, 0, 0, 1, 0, 0, 0);
    step();
    chk("xs_busy", busy_o, 32'h706);
    exec_stall_i = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("xs_i1", o_i1, 0);
      chk("xs_st", o_st, 1);
    end
    exec_stall_i = 0;
    flush_i = 1;
    step();
    chk("fl_i1", o_i1, 0);
    chk("fl_st", o_st, 0);
    chk("fl_busy", busy_o, 32'h706);
    idle();
    set0(1, 0, 0, 11, 0, 0, 1, 0);
    set1(1, 0, 0, 12, 0, 0, 1, 0);
    step();
    chk("fl_pair_i0", o_i0, 1);
    chk("fl_pair_i1", o_i1, 1);
    idle();

    // Fill every register, sit in HALF, then reset.
    reset_i = 1;
    step();
    idle();
    for (int k = 1; k <= 15; k++) begin
      set0(1, 0, 0, 2 * k - 1, 0, 0, 1, 0);
      set1(1, 0, 0, 2 * k, 0, 0, 1, 0);
      step();
    end
    set0(1, 0, 0, 31, 0, 0, 1, 0);
    set1(1, 31, 0, 0, 1, 0, 0, 0);
    step();
    chk("full_busy", busy_o, 32'hFFFF_FFFE);
    reset_i = 1;
    wb_we0_i = 1; wb_addr0_i = 31;
    flush_i = 1;
    step();
    chk("rh_i1", o_i1, 0);
    chk("rh_st", o_st, 0);
    chk("rh_busy", busy_o, 32'h0);
    idle();
    set0(1, 0, 0, 4, 0, 0, 1, 0);
    set1(1, 0, 0, 6, 0, 0, 1, 0);
    step();
    chk("rh_pair_i0", o_i0, 1);
    idle();

    // Random traffic; a stalled pair is held as upstream would.
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        set0($urandom_range(7) != 0, $urandom_range(15), $urandom_range(15), $urandom_range(15),
             1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(3) == 0);
        set1($urandom_range(3) != 0, $urandom_range(15), $urandom_range(15), $urandom_range(15),
             1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(3) == 0);
      end
      wb_we0_i = 1'($urandom); wb_addr0_i = 5'($urandom_range(15));
      wb_we1_i = 1'($urandom); wb_addr1_i = 5'($urandom_range(15));
      exec_stall_i = $urandom_range(7) == 0;
      flush_i = $urandom_range(19) == 0;
      reset_i = $urandom_range(99) == 0;
      step();
      hold = o_st;
    end
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
